// File: rtl/node_sigma_if.sv
// node_sigma_if: input/output handshake, operand bundle and status for node_sigma.
interface node_sigma_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] bundle_in_0;
    logic [WIDTH-1:0] bundle_in_1;
    logic [1:0]       mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bundle_out;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        output in_valid, bundle_in_0, bundle_in_1, mode, flush, out_ready,
        input  in_ready, out_valid, bundle_out, out_count, busy
    );
    modport slave (
        input  in_valid, bundle_in_0, bundle_in_1, mode, flush, out_ready,
        output in_ready, out_valid, bundle_out, out_count, busy
    );
endinterface

// File: rtl/node_sigma.sv
// node_sigma: pipelined multi-lane rotate/mix node with valid/ready handshake,
// flush and a wrapping output-transfer counter.
module node_sigma #(
    parameter int WIDTH = 32,
    parameter int LANES = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    node_sigma_if.slave bus
);
    logic             adv;
    logic             take;
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [WIDTH-1:0] mix [LANES];
    logic [WIDTH-1:0] red;
    logic [CNT_W-1:0] cnt;

    assign adv            = !vld[DEPTH-1] || bus.out_ready;
    assign bus.in_ready   = adv && !bus.flush;
    assign take           = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = vld[DEPTH-1];
    assign bus.bundle_out = dat[DEPTH-1];
    assign bus.out_count  = cnt;
    assign bus.busy       = |vld;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int R = k % WIDTH;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        if (R == 0) begin : g_id
            assign a = bus.bundle_in_0;
            assign b = bus.bundle_in_1;
        end else begin : g_rot
            assign a = {bus.bundle_in_0[WIDTH-1-R:0], bus.bundle_in_0[WIDTH-1:WIDTH-R]};
            assign b = {bus.bundle_in_1[R-1:0], bus.bundle_in_1[WIDTH-1:R]};
        end
        assign mix[k] = bus.mode == 2'd0 ? a + b :
                        bus.mode == 2'd1 ? a ^ b :
                        bus.mode == 2'd2 ? a | b : a - b;
    end

    always_comb begin
        red = '0;
        for (int i = 0; i < LANES; i++) red = red ^ mix[i];
    end

    // Payload shifts with adv regardless of flush; only the valids are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) cnt <= cnt + CNT_W'(1);
            if (bus.flush) vld <= '0;
            else if (adv) vld <= DEPTH'({vld, take});
            if (adv) begin
                dat[0] <= red & bus.bundle_in_0;
                for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
            end
        end
    end
endmodule

// File: tb/tb_node_sigma.sv
// tb_node_sigma: table-driven and scoreboard checks of node_sigma handshake,
// mixing, backpressure, flush, async reset and counter wrap.
module tb_node_sigma;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    node_sigma_if #(.WIDTH(32), .CNT_W(16)) bus ();
    node_sigma #(.WIDTH(32), .LANES(3), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  md;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] q [$];
    int          pass_n = 0;
    int          total_n = 0;
    logic [15:0] exp_cnt = '0;
    bit          held = 1'b0;
    logic [31:0] held_d = '0;
    bit          have_exp = 1'b0;
    logic [31:0] next_exp = '0;

    function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [1:0] md);
        logic [31:0] x, ak, bk, m;
        x = '0;
        for (int k = 0; k < 3; k++) begin
            ak = (k == 0) ? a : ((a << k) | (a >> (32 - k)));
            bk = (k == 0) ? b : ((b >> k) | (b << (32 - k)));
            case (md)
                2'd0:    m = ak + bk;
                2'd1:    m = ak ^ bk;
                2'd2:    m = ak | bk;
                default: m = ak - bk;
            endcase
            x = x ^ m;
        end
        return x & a;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic chkb(string name, logic act, logic req);
        total_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s: got %b want %b", name, act, req);
    endtask

    // One clock: sample 1 unit after the falling edge, score, then wait for the next falling edge.
    task automatic cycle(output bit acc);
        #1;
        acc = bus.in_valid && bus.in_ready;
        chkb("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready) && !bus.flush);
        chk("out_count", 32'(bus.out_count), 32'(exp_cnt));
        chkb("busy", bus.busy, q.size() != 0);
        if (held) begin
            chkb("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.bundle_out, held_d);
        end
        held = bus.out_valid && !bus.out_ready && !bus.flush;
        held_d = bus.bundle_out;
        if (bus.out_valid && bus.out_ready) begin
            exp_cnt++;
            if (q.size() == 0) begin
                total_n++;
                $display("FAIL unexpected_out: got %h want no output", bus.bundle_out);
            end else chk("data", bus.bundle_out, q.pop_front());
        end
        if (bus.flush) q.delete();
        if (acc) q.push_back(have_exp ? next_exp : model(bus.bundle_in_0, bus.bundle_in_1, bus.mode));
        @(negedge clk);
    endtask

    task automatic send(logic [31:0] a, logic [31:0] b, logic [1:0] md, bit he, logic [31:0] e);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.bundle_in_0 = a;
        bus.bundle_in_1 = b;
        bus.mode = md;
        have_exp = he;
        next_exp = e;
        for (int t = 0; t < 50 && !acc; t++) cycle(acc);
        if (!acc) begin
            total_n++;
            $display("FAIL send_timeout: got no accept want accept");
        end
        have_exp = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int t = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0 || bus.busy) && t < 20) begin
            cycle(acc);
            t++;
        end
        if (q.size() != 0 || bus.busy) begin
            total_n++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
    endtask

    task automatic hard_reset();
        #2 rst_n = 1'b0;
        #1;
        chkb("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_bundle_out", bus.bundle_out, 32'h0);
        chk("rst_out_count", 32'(bus.out_count), 32'h0);
        chkb("rst_busy", bus.busy, 1'b0);
        q.delete();
        exp_cnt = '0;
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bit saw_block;
        int j;
        int t;
        logic [15:0] c0;
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 32'h4000_0000};
        tbl[2] = '{32'h0000_00F0, 32'h0F00_0000, 2'd2, 32'h0000_00D0};
        tbl[3] = '{32'h0000_0000, 32'h1234_5678, 2'd3, 32'h0000_0000};
        tbl[4] = '{32'h0000_0001, 32'h0000_0000, 2'd1, 32'h0000_0001};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'd3, 32'h3FFF_FFFE};
        tbl[6] = '{32'h8000_0000, 32'h0000_0000, 2'd2, 32'h8000_0000};
        bus.in_valid = 1'b0;
        bus.bundle_in_0 = '0;
        bus.bundle_in_1 = '0;
        bus.mode = 2'd0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;

        #3;
        chkb("init_out_valid", bus.out_valid, 1'b0);
        chk("init_bundle_out", bus.bundle_out, 32'h0);
        chk("init_out_count", 32'(bus.out_count), 32'h0);
        chkb("init_busy", bus.busy, 1'b0);
        chkb("init_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: visible exactly two edges after acceptance.
        bus.out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'h0, 2'd1, 1'b1, 32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        chkb("lat_early", bus.out_valid, 1'b0);
        cycle(acc);
        chkb("lat_exact", bus.out_valid, 1'b1);
        cycle(acc);
        chk("lat_count", 32'(bus.out_count), 32'd1);

        for (int i = 0; i < 7; i++) send(tbl[i].a, tbl[i].b, tbl[i].md, 1'b1, tbl[i].exp);
        drain();

        // Backpressure: consumer stalls for the first 5 cycles.
        c0 = bus.out_count;
        saw_block = 1'b0;
        j = 0;
        t = 0;
        while (j < 4 && t < 40) begin
            bus.in_valid = 1'b1;
            bus.bundle_in_0 = 32'h1111_1111 * (j + 1);
            bus.bundle_in_1 = 32'(j * 7 + 3);
            bus.mode = 2'(j);
            bus.out_ready = (t >= 5);
            cycle(acc);
            if (acc) j++;
            else if (t < 5) saw_block = 1'b1;
            t++;
        end
        chkb("bp_in_ready_fell", saw_block, 1'b1);
        drain();
        chk("bp_count", 32'(bus.out_count), 32'(c0 + 16'd4));

        // Flush with both beats stalled in the pipeline.
        c0 = bus.out_count;
        bus.out_ready = 1'b0;
        send(32'hA5A5_0F0F, 32'h1234_0000, 2'd0, 1'b0, 32'h0);
        send(32'h0F0F_A5A5, 32'h0000_4321, 2'd3, 1'b0, 32'h0);
        bus.bundle_in_0 = 32'hDEAD_BEEF;
        bus.flush = 1'b1;
        #1;
        chkb("flush_in_ready", bus.in_ready, 1'b0);
        chkb("flush_out_valid_pre", bus.out_valid, 1'b1);
        cycle(acc);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chkb("flush_busy", bus.busy, 1'b0);
        chkb("flush_out_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        cycle(acc);
        cycle(acc);
        chkb("flush_no_out", bus.out_valid, 1'b0);
        chk("flush_count", 32'(bus.out_count), 32'(c0));

        // Flush coinciding with an output handshake: the transfer still counts.
        send(32'h0000_FFFF, 32'h0000_0F0F, 2'd1, 1'b0, 32'h0);
        bus.in_valid = 1'b0;
        cycle(acc);
        bus.flush = 1'b1;
        cycle(acc);
        bus.flush = 1'b0;
        chk("flush_hs_count", 32'(bus.out_count), 32'(c0 + 16'd1));
        chkb("flush_hs_busy", bus.busy, 1'b0);

        // Asynchronous reset with beats in flight.
        bus.out_ready = 1'b0;
        send(32'h1357_9BDF, 32'h2468_ACE0, 2'd0, 1'b0, 32'h0);
        send(32'hFFFF_0000, 32'h00FF_FF00, 2'd2, 1'b0, 32'h0);
        bus.in_valid = 1'b0;
        chkb("pre_rst_out_valid", bus.out_valid, 1'b1);
        hard_reset();
        bus.out_ready = 1'b1;
        send(32'h0000_00F0, 32'h0F00_0000, 2'd2, 1'b1, 32'h0000_00D0);
        drain();
        chk("post_rst_count", 32'(bus.out_count), 32'd1);

        // Counter wrap over 65536 back-to-back transfers.
        hard_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65536; i++)
            send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, 32'h0);
        drain();
        chk("wrap_zero", 32'(bus.out_count), 32'h0);
        send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0, 32'h0);
        drain();
        chk("wrap_one", 32'(bus.out_count), 32'h1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
